// File: rtl/letc_core_branch_resolve_pkg.sv
// letc_core_branch_resolve_pkg: shared types for execute-stage branch resolution
package letc_core_branch_resolve_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {BR_NONE, BR_COND, BR_JAL, BR_JALR} branch_type_e;
  typedef enum logic {BRR_IDLE, BRR_REDIRECT} br_resolve_state_e;
endpackage

// File: rtl/letc_core_branch_resolve_if.sv
// letc_core_branch_resolve_if: execute op, fetch redirect, writeback and status signals
interface letc_core_branch_resolve_if #(parameter int CNT_W = 32);
  import letc_core_branch_resolve_pkg::*;
  logic i_valid;
  logic o_ready;
  logic i_is_branch;
  logic i_is_jal;
  logic i_is_jalr;
  word_t i_pc;
  word_t i_imm;
  word_t i_rs1;
  logic i_cmp_result;
  logic i_flush;
  logic o_redirect_valid;
  logic i_redirect_ready;
  word_t o_redirect_pc;
  logic o_flush;
  logic o_wb_valid;
  word_t o_wb_link;
  logic o_misaligned;
  word_t o_misaligned_addr;
  logic [CNT_W-1:0] o_taken_count;
  modport master (
    output i_valid, i_is_branch, i_is_jal, i_is_jalr, i_pc, i_imm, i_rs1, i_cmp_result, i_flush, i_redirect_ready,
    input o_ready, o_redirect_valid, o_redirect_pc, o_flush, o_wb_valid, o_wb_link, o_misaligned, o_misaligned_addr, o_taken_count
  );
  modport slave (
    input i_valid, i_is_branch, i_is_jal, i_is_jalr, i_pc, i_imm, i_rs1, i_cmp_result, i_flush, i_redirect_ready,
    output o_ready, o_redirect_valid, o_redirect_pc, o_flush, o_wb_valid, o_wb_link, o_misaligned, o_misaligned_addr, o_taken_count
  );
endinterface

// File: rtl/letc_core_branch_resolve.sv
// letc_core_branch_resolve: resolves branches/jumps, issues redirect, flush, link and taken count
module letc_core_branch_resolve
  import letc_core_branch_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic i_clk,
  input logic i_rst,
  letc_core_branch_resolve_if.slave bus
);
  br_resolve_state_e state, state_n;
  branch_type_e bt;
  word_t sum, target;
  logic taken, accept, go, mis;
  logic [CNT_W-1:0] cnt;
  assign bus.o_ready = (state == BRR_IDLE) && !bus.i_flush;
  assign bus.o_redirect_valid = (state == BRR_REDIRECT);
  assign bus.o_taken_count = cnt;
  // decode op, compute target and next state; flush overrides accept and handshake
  always_comb begin
    bt = bus.i_is_jal ? BR_JAL : bus.i_is_jalr ? BR_JALR : bus.i_is_branch ? BR_COND : BR_NONE;
    sum = (bt == BR_JALR ? bus.i_rs1 : bus.i_pc) + bus.i_imm;
    target = {sum[31:1], sum[0] & (bt != BR_JALR)};
    taken = (bt == BR_JAL) || (bt == BR_JALR) || (bt == BR_COND && bus.i_cmp_result);
    accept = bus.i_valid && bus.o_ready;
    go = accept && taken && !target[1];
    mis = accept && taken && target[1];
    state_n = bus.i_flush ? BRR_IDLE : go ? BRR_REDIRECT :
              (state == BRR_REDIRECT && !bus.i_redirect_ready) ? BRR_REDIRECT : BRR_IDLE;
  end
  // registered outputs; target/link/addr hold until the next event that owns them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= BRR_IDLE;
      bus.o_redirect_pc <= '0;
      bus.o_flush <= 1'b0;
      bus.o_wb_valid <= 1'b0;
      bus.o_wb_link <= '0;
      bus.o_misaligned <= 1'b0;
      bus.o_misaligned_addr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      bus.o_flush <= go;
      bus.o_wb_valid <= go && bt != BR_COND;
      bus.o_misaligned <= mis;
      cnt <= cnt + CNT_W'(go);
      if (go) bus.o_redirect_pc <= target;
      if (go) bus.o_wb_link <= bus.i_pc + 32'd4;
      if (mis) bus.o_misaligned_addr <= target;
    end
  end
  a_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.i_valid |-> $onehot({bus.i_is_branch, bus.i_is_jal, bus.i_is_jalr}));
endmodule

// File: tb/tb_letc_core_branch_resolve.sv
// tb_letc_core_branch_resolve: random + directed bench against a behavioural model
module tb_letc_core_branch_resolve;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  letc_core_branch_resolve_if #(.CNT_W(32)) bif ();
  letc_core_branch_resolve_if #(.CNT_W(2)) bif2 ();
  letc_core_branch_resolve #(.CNT_W(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bif.slave));
  letc_core_branch_resolve #(.CNT_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bif2.slave));
  assign bif2.i_valid = bif.i_valid;
  assign bif2.i_is_branch = bif.i_is_branch;
  assign bif2.i_is_jal = bif.i_is_jal;
  assign bif2.i_is_jalr = bif.i_is_jalr;
  assign bif2.i_pc = bif.i_pc;
  assign bif2.i_imm = bif.i_imm;
  assign bif2.i_rs1 = bif.i_rs1;
  assign bif2.i_cmp_result = bif.i_cmp_result;
  assign bif2.i_flush = bif.i_flush;
  assign bif2.i_redirect_ready = bif.i_redirect_ready;
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // behavioural model: one outstanding redirect, events visible one cycle after accept
  logic m_pending, m_flush, m_wb, m_mis_p;
  logic [31:0] m_rpc, m_link, m_mis_addr, m_cnt;
  logic [31:0] m_tgt;
  logic m_acc, m_tk, m_go, m_mis;
  assign m_tgt = bif.i_is_jalr ? ((bif.i_rs1 + bif.i_imm) & ~32'd1) : bif.i_pc + bif.i_imm;
  assign m_acc = bif.i_valid && !m_pending && !bif.i_flush;
  assign m_tk = bif.i_is_jal || bif.i_is_jalr || (bif.i_is_branch && bif.i_cmp_result);
  assign m_go = m_acc && m_tk && !m_tgt[1];
  assign m_mis = m_acc && m_tk && m_tgt[1];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 0; m_flush <= 0; m_wb <= 0; m_mis_p <= 0;
      m_rpc <= 0; m_link <= 0; m_mis_addr <= 0; m_cnt <= 0;
    end else begin
      m_pending <= bif.i_flush ? 1'b0 : m_pending ? !bif.i_redirect_ready : m_go;
      m_flush <= m_go;
      m_wb <= m_go && !bif.i_is_branch;
      m_mis_p <= m_mis;
      m_cnt <= m_cnt + 32'(m_go);
      if (m_go) m_rpc <= m_tgt;
      if (m_go) m_link <= bif.i_pc + 32'd4;
      if (m_mis) m_mis_addr <= m_tgt;
    end
  end
  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      chk("redirect_valid", 32'(bif.o_redirect_valid), 32'(m_pending));
      if (m_pending) chk("redirect_pc", bif.o_redirect_pc, m_rpc);
      chk("flush", 32'(bif.o_flush), 32'(m_flush));
      chk("wb_valid", 32'(bif.o_wb_valid), 32'(m_wb));
      if (m_wb) chk("wb_link", bif.o_wb_link, m_link);
      chk("misaligned", 32'(bif.o_misaligned), 32'(m_mis_p));
      if (m_mis_p) chk("mis_addr", bif.o_misaligned_addr, m_mis_addr);
      chk("taken_count", bif.o_taken_count, m_cnt);
      chk("taken_count_w2", 32'(bif2.o_taken_count), m_cnt & 32'd3);
    end
  end
  // kind: 0 branch, 1 jal, 2 jalr
  task automatic drive(input logic v, input int kind, input logic [31:0] pc, imm, rs1,
                       input logic cmp, fl, rr);
    bif.i_valid = v;
    bif.i_is_branch = kind == 0;
    bif.i_is_jal = kind == 1;
    bif.i_is_jalr = kind == 2;
    bif.i_pc = pc;
    bif.i_imm = imm;
    bif.i_rs1 = rs1;
    bif.i_cmp_result = cmp;
    bif.i_flush = fl;
    bif.i_redirect_ready = rr;
    #1;
    chk("ready", 32'(bif.o_ready), 32'(!m_pending && !fl));
    @(negedge clk);
  endtask
  task automatic idle(input logic rr);
    drive(0, 0, 0, 0, 0, 0, 0, rr);
  endtask
  initial begin
    bif.i_valid = 0; bif.i_is_branch = 0; bif.i_is_jal = 0; bif.i_is_jalr = 0;
    bif.i_pc = 0; bif.i_imm = 0; bif.i_rs1 = 0; bif.i_cmp_result = 0;
    bif.i_flush = 0; bif.i_redirect_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_redirect_valid", 32'(bif.o_redirect_valid), 0);
    chk("rst_redirect_pc", bif.o_redirect_pc, 0);
    chk("rst_count", bif.o_taken_count, 0);
    chk("rst_wb_link", bif.o_wb_link, 0);
    rst = 0;
    idle(1);
    // taken BEQ
    drive(1, 0, 32'h1000, 32'h40, 0, 1, 0, 1);
    chk("beq_valid", 32'(bif.o_redirect_valid), 1);
    chk("beq_pc", bif.o_redirect_pc, 32'h1040);
    chk("beq_flush", 32'(bif.o_flush), 1);
    chk("beq_count", bif.o_taken_count, 1);
    idle(1);
    chk("beq_ready_after", 32'(bif.o_ready), 1);
    // JAL under backpressure
    drive(1, 1, 32'h2000, 32'hFFFF_FFF0, 0, 0, 0, 0);
    chk("jal_wb_valid", 32'(bif.o_wb_valid), 1);
    chk("jal_wb_link", bif.o_wb_link, 32'h2004);
    for (int i = 0; i < 4; i++) begin
      chk("bp_pc", bif.o_redirect_pc, 32'h1FF0);
      chk("bp_valid", 32'(bif.o_redirect_valid), 1);
      chk("bp_flush", 32'(bif.o_flush), 32'(i == 0));
      chk("bp_ready", 32'(bif.o_ready), 0);
      idle(i == 3);
    end
    chk("bp_released", 32'(bif.o_redirect_valid), 0);
    // JALR aligned and misaligned
    drive(1, 2, 0, 32'h4, 32'h3001, 0, 0, 1);
    chk("jalr_pc", bif.o_redirect_pc, 32'h3004);
    idle(1);
    drive(1, 2, 0, 0, 32'h3002, 0, 0, 1);
    chk("mis_pulse", 32'(bif.o_misaligned), 1);
    chk("mis_addr_lit", bif.o_misaligned_addr, 32'h3002);
    chk("mis_no_redirect", 32'(bif.o_redirect_valid), 0);
    chk("mis_count", bif.o_taken_count, 3);
    // not-taken BNE back-to-back
    for (int i = 0; i < 4; i++) drive(1, 0, 32'h500 + 4 * i, 32'h20, 0, 0, 0, 1);
    chk("bne_count", bif.o_taken_count, 3);
    chk("bne_flush", 32'(bif.o_flush), 0);
    // flush during REDIRECT and flush with valid
    drive(1, 1, 32'h100, 32'h8, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_drop", 32'(bif.o_redirect_valid), 0);
    drive(1, 1, 32'h200, 32'h8, 0, 0, 1, 1);
    chk("flush_op_wb", 32'(bif.o_wb_valid), 0);
    chk("flush_op_count", bif.o_taken_count, 4);
    // link wrap
    drive(1, 1, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 1);
    chk("link_wrap", bif.o_wb_link, 32'h0);
    idle(1);
    // narrow counter wrap
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h800, 32'h10, 0, 1, 0, 1);
      idle(1);
    end
    chk("count32", bif.o_taken_count, 10);
    chk("count2_wrap", 32'(bif2.o_taken_count), 2);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)), $urandom & ~32'd3, $urandom,
            $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
    end
    idle(1);
    // async reset mid-redirect
    drive(1, 1, 32'h4000, 32'h40, 0, 0, 0, 0);
    bif.i_valid = 0;
    chk("pre_rst_valid", 32'(bif.o_redirect_valid), 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(bif.o_redirect_valid), 0);
    chk("arst_pc", bif.o_redirect_pc, 0);
    chk("arst_flush", 32'(bif.o_flush), 0);
    chk("arst_wb", 32'(bif.o_wb_valid), 0);
    chk("arst_link", bif.o_wb_link, 0);
    chk("arst_mis", 32'(bif.o_misaligned), 0);
    chk("arst_mis_addr", bif.o_misaligned_addr, 0);
    chk("arst_count", bif.o_taken_count, 0);
    chk("arst_count2", 32'(bif2.o_taken_count), 0);
    @(negedge clk);
    rst = 0;
    idle(1);
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/letc_core_branch_resolve.md
Name: letc_core_branch_resolve

Overview:
- Execute-stage consumer of the branch comparator result. Decides branch/jump outcome and computes the target.
- Issues a registered redirect to fetch with a valid/ready handshake and pulses a pipeline flush on every taken control transfer.
- Static prediction is always not-taken, so only taken branches, JAL and JALR redirect.
- Also produces the JAL/JALR link value for writeback and a taken-transfer performance counter.

Parameters:
- CNT_W, 32, width of the taken-transfer counter (legal range 1..32).

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  asynchronous active-high reset
- i_valid  input  1  execute presents a control-flow op
- o_ready  output  1  block can accept an op this cycle
- i_is_branch  input  1  conditional branch (B-type)
- i_is_jal  input  1  JAL
- i_is_jalr  input  1  JALR
- i_pc  input  32  word_t PC of the op
- i_imm  input  32  word_t sign-extended immediate
- i_rs1  input  32  word_t rs1 value (JALR base)
- i_cmp_result  input  1  comparator output for this op
- i_flush  input  1  higher-priority flush (trap/exception)
- o_redirect_valid  output  1  redirect request to fetch
- i_redirect_ready  input  1  fetch accepts redirect
- o_redirect_pc  output  32  word_t redirect target
- o_flush  output  1  one-cycle flush pulse to younger stages
- o_wb_valid  output  1  link value valid (one-cycle pulse)
- o_wb_link  output  32  word_t i_pc+4 of a JAL/JALR
- o_misaligned  output  1  one-cycle pulse: taken target not 4-byte aligned
- o_misaligned_addr  output  32  word_t offending target
- o_taken_count  output  CNT_W  taken-transfer count

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_redirect_valid=0, o_redirect_pc=0, o_flush=0, o_wb_valid=0, o_wb_link=0, o_misaligned=0, o_misaligned_addr=0, o_taken_count=0.
- Reset deasserts synchronously to i_clk; reset mid-redirect drops the request immediately.
- Accept: i_valid && o_ready; o_ready = (state==IDLE) && !i_flush.
- Exactly one of i_is_branch/i_is_jal/i_is_jalr is set when i_valid=1; other cases are illegal (SVA).
- Target:
  - Branch/JAL: i_pc+i_imm.
  - JALR: (i_rs1+i_imm) with bit0 cleared.
  - All adds are 32-bit and wrap modulo 2^32.
- Taken: (i_is_branch && i_cmp_result) || i_is_jal || i_is_jalr.
- State machine:
  - IDLE -> REDIRECT when an op is accepted, taken, and target[1]==0.
  - REDIRECT -> IDLE when o_redirect_valid && i_redirect_ready.
  - Any state -> IDLE when i_flush=1. i_flush takes priority over both the accept and the handshake.
- Timing and latency:
  - All outputs are registered; latency is 1 cycle from accept.
  - o_redirect_valid rises the cycle after accept. o_flush pulses high for exactly that first cycle only.
  - o_redirect_pc holds stable while o_redirect_valid && !i_redirect_ready.
  - The same-cycle handshake releases state, so o_ready=1 on the next cycle.
- Misaligned (taken && target[1]==1):
  - No redirect and no o_flush; state stays IDLE.
  - o_misaligned pulses 1 cycle later with o_misaligned_addr=target.
  - o_wb_valid stays 0 for this op (the trap squashes it).
  - Counter is not incremented.
- Not-taken branch: no outputs asserted apart from o_ready staying 1.
- JAL/JALR (aligned): o_wb_valid pulses 1 cycle after accept with o_wb_link=i_pc+4 (wraps at 2^32). This is independent of redirect acceptance.
- o_taken_count increments on every accepted, aligned, taken op. It wraps from all-ones to 0 and is not cleared by i_flush.
- Accepts gated by i_flush produce no side effects.

Decomposition:
- Shared package additions:
  - letc_core_pkg: branch_type_e enum (BR_NONE, BR_COND, BR_JAL, BR_JALR).
  - letc_core_pkg: br_resolve_state_e (BRR_IDLE, BRR_REDIRECT).
  - letc_pkg: reuses word_t.
- Single module. No sub-module; letc_core_branch_comparator is instantiated alongside it in execute, not inside it.

Test Plan:
1. Taken BEQ: i_pc=0x1000, i_imm=0x40, i_cmp_result=1, i_redirect_ready=1 -> next cycle o_redirect_valid=1, o_redirect_pc=0x1040, o_flush=1, o_taken_count=1; o_ready=1 the cycle after.
2. Backpressure: JAL i_pc=0x2000, i_imm=0xFFFFFFF0, i_redirect_ready=0 for 3 cycles, then 1:
   - o_redirect_pc=0x1FF0 stable for 4 cycles.
   - o_flush high only in the first of those cycles.
   - o_ready=0 throughout.
   - o_wb_valid pulses once with o_wb_link=0x2004.
3. JALR: i_rs1=0x3001, i_imm=0x4 -> o_redirect_pc=0x3004 (bit0 cleared). JALR i_rs1=0x3002, i_imm=0 -> o_misaligned=1, o_misaligned_addr=0x3002, no redirect, counter unchanged.
4. Not-taken BNE (i_cmp_result=0) back-to-back for 4 cycles -> no redirect/flush/wb, o_ready=1 every cycle, counter unchanged.
5. i_flush=1 while in REDIRECT with i_redirect_ready=0 -> next cycle o_redirect_valid=0 and IDLE. i_flush together with i_valid -> op dropped.
6. Wrap and reset:
   - CNT_W=2, 5 taken branches -> o_taken_count=1.
   - JAL with i_pc=0xFFFFFFFC -> o_wb_link=0x0.
   - Assert i_rst mid-REDIRECT -> all outputs 0 immediately, asynchronously.
